// File: rtl/cv32e40x_pkg.sv
// Shared opcode and state encodings for the EX-stage iterative divider.
// Opcode bit 0 marks unsigned ops, bit 1 selects the remainder.
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        DIV_DIV  = 2'b00,
        DIV_DIVU = 2'b01,
        DIV_REM  = 2'b10,
        DIV_REMU = 2'b11
    } div_opcode_e;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_INIT,
        DIV_DIVIDE,
        DIV_FINISH
    } div_state_e;

    localparam logic [5:0] DIV_CLZ_ZERO = 6'd32;

endpackage

// File: rtl/cv32e40x_div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Borrows the ALU CLZ and shifter for one cycle to normalise the divisor.
module cv32e40x_div
    import cv32e40x_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  operator_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        kill_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic [31:0] div_alu_op_a_o,
    output logic        div_clz_en_o,
    output logic [31:0] div_clz_data_o,
    input  logic [5:0]  div_clz_result_i,
    output logic        div_shift_en_o,
    output logic [5:0]  div_shift_amt_o,
    input  logic [31:0] div_op_a_shifted_i
);

    div_state_e  state_q, state_d;
    div_opcode_e op_q, op_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] d_q, d_d;
    logic [31:0] q_q, q_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;

    logic        op_signed;
    logic        neg_a;
    logic        neg_b;
    logic        div_by_zero;
    logic        rem_ge_d;
    logic [31:0] rem_sub;
    logic [31:0] quo_res;
    logic [31:0] rem_res;

    assign op_signed   = ~operator_i[0];
    assign neg_a       = op_signed & op_a_i[31];
    assign neg_b       = op_signed & op_b_i[31];
    assign div_by_zero = (div_clz_result_i == DIV_CLZ_ZERO);
    assign rem_ge_d    = (rem_q >= d_q);
    assign rem_sub     = rem_q - d_q;
    assign quo_res     = (sign_a_q ^ sign_b_q) ? -q_q : q_q;
    assign rem_res     = sign_a_q ? -rem_q : rem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (kill_i) begin
            state_d = DIV_IDLE;
        end else begin
            unique case (state_q)
                DIV_IDLE:   if (valid_i) state_d = DIV_INIT;
                DIV_INIT:   state_d = div_by_zero ? DIV_FINISH : DIV_DIVIDE;
                DIV_DIVIDE: if (cnt_q == 6'd0) state_d = DIV_FINISH;
                DIV_FINISH: if (ready_i) state_d = DIV_IDLE;
                default:    state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= DIV_DIV;
            rem_q    <= '0;
            d_q      <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else begin
            op_q     <= op_d;
            rem_q    <= rem_d;
            d_q      <= d_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
        end
    end

    always_comb begin
        op_d     = op_q;
        rem_d    = rem_q;
        d_d      = d_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (valid_i && !kill_i) begin
                    op_d     = div_opcode_e'(operator_i);
                    sign_a_d = neg_a;
                    sign_b_d = neg_b;
                    rem_d    = neg_a ? -op_a_i : op_a_i;
                    d_d      = neg_b ? -op_b_i : op_b_i;
                    q_d      = '0;
                    cnt_d    = '0;
                end
            end
            DIV_INIT: begin
                if (div_by_zero) begin
                    // Restore the original dividend; clearing the signs skips correction.
                    q_d      = '1;
                    rem_d    = rem_res;
                    sign_a_d = 1'b0;
                    sign_b_d = 1'b0;
                end else begin
                    d_d   = div_op_a_shifted_i;
                    q_d   = '0;
                    cnt_d = div_clz_result_i;
                end
            end
            DIV_DIVIDE: begin
                if (rem_ge_d) rem_d = rem_sub;
                q_d   = {q_q[30:0], rem_ge_d};
                d_d   = d_q >> 1;
                cnt_d = cnt_q - 6'd1;
            end
            DIV_FINISH: begin
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        ready_o         = 1'b0;
        valid_o         = 1'b0;
        result_o        = '0;
        div_clz_en_o    = 1'b0;
        div_shift_en_o  = 1'b0;
        div_alu_op_a_o  = '0;
        div_clz_data_o  = '0;
        div_shift_amt_o = '0;
        unique case (state_q)
            DIV_IDLE: begin
                ready_o = 1'b1;
            end
            DIV_INIT: begin
                div_clz_en_o    = 1'b1;
                div_shift_en_o  = 1'b1;
                div_alu_op_a_o  = d_q;
                div_clz_data_o  = d_q;
                div_shift_amt_o = div_clz_result_i;
            end
            DIV_DIVIDE: begin
            end
            DIV_FINISH: begin
                valid_o = ~kill_i;
                unique case (op_q)
                    DIV_DIV, DIV_DIVU: result_o = quo_res;
                    default:           result_o = rem_res;
                endcase
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cv32e40x_div.sv
// Self-checking bench for cv32e40x_div against an RV32M arithmetic model.
// The bench also plays the ALU, serving the borrowed CLZ and shifter.
module tb_cv32e40x_div;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  operator_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        kill_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic [31:0] div_alu_op_a_o;
    logic        div_clz_en_o;
    logic [31:0] div_clz_data_o;
    logic [5:0]  div_clz_result_i;
    logic        div_shift_en_o;
    logic [5:0]  div_shift_amt_o;
    logic [31:0] div_op_a_shifted_i;

    int          errors = 0;
    int          checks = 0;
    logic        pending = 1'b0;
    logic [31:0] exp_res = '0;

    cv32e40x_div dut (
        .clk                (clk),
        .rst                (rst),
        .valid_i            (valid_i),
        .ready_o            (ready_o),
        .operator_i         (operator_i),
        .op_a_i             (op_a_i),
        .op_b_i             (op_b_i),
        .kill_i             (kill_i),
        .valid_o            (valid_o),
        .ready_i            (ready_i),
        .result_o           (result_o),
        .div_alu_op_a_o     (div_alu_op_a_o),
        .div_clz_en_o       (div_clz_en_o),
        .div_clz_data_o     (div_clz_data_o),
        .div_clz_result_i   (div_clz_result_i),
        .div_shift_en_o     (div_shift_en_o),
        .div_shift_amt_o    (div_shift_amt_o),
        .div_op_a_shifted_i (div_op_a_shifted_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clz(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) return 31 - i;
        end
        return 32;
    endfunction

    always_comb begin
        div_clz_result_i   = 6'(clz(div_clz_data_o));
        div_op_a_shifted_i = div_alu_op_a_o << div_shift_amt_o;
    end

    // RV32M results straight from signed/unsigned integer arithmetic
    function automatic logic [31:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'b00: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return sa / sb;
            end
            2'b01: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            2'b10: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return sa % sb;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        logic [31:0] mag;
        if (b == 0) return 2;
        mag = (!op[0] && b[31]) ? -b : b;
        if (a == 32'h1234_5678) return clz(mag) + 3;
        return clz(mag) + 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(ready_o), 32'd1);
        chk({tag, "_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_result"}, result_o, 32'd0);
        chk({tag, "_clz_en"}, 32'(div_clz_en_o), 32'd0);
        chk({tag, "_shift_en"}, 32'(div_shift_en_o), 32'd0);
        chk({tag, "_alu_a"}, div_alu_op_a_o, 32'd0);
        chk({tag, "_clz_data"}, div_clz_data_o, 32'd0);
        chk({tag, "_shift_amt"}, 32'(div_shift_amt_o), 32'd0);
    endtask

    // Every cycle with a result on the bus is compared against the model
    always @(negedge clk) begin
        if (!rst && valid_o) begin
            checks++;
            if (!pending) begin
                errors++;
                $display("FAIL unexpected_valid: got result 0x%08h expected no valid_o", result_o);
            end else if (result_o !== exp_res) begin
                errors++;
                $display("FAIL result: got 0x%08h expected 0x%08h", result_o, exp_res);
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold,
                          input logic [31:0] lit, input int lit_lat,
                          input bit use_lit);
        int          n;
        int          lat;
        logic [31:0] held;
        lat     = exp_lat(op, a, b);
        exp_res = model(op, a, b);
        pending = 1'b1;
        chk("idle_ready", 32'(ready_o), 32'd1);
        valid_i    = 1'b1;
        operator_i = op;
        op_a_i     = a;
        op_b_i     = b;
        @(negedge clk);
        valid_i = 1'b0;
        op_a_i  = $urandom;
        op_b_i  = $urandom;
        n = 1;
        while (!valid_o && n < 64) begin
            chk("busy_ready", 32'(ready_o), 32'd0);
            @(negedge clk);
            n++;
        end
        chk_int("latency", n, lat);
        if (use_lit) begin
            chk("lit_result", result_o, lit);
            chk_int("lit_latency", n, lit_lat);
        end
        held = result_o;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(valid_o), 32'd1);
            chk("hold_result", result_o, held);
            chk("hold_ready", 32'(ready_o), 32'd0);
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        pending = 1'b0;
        chk("post_ready", 32'(ready_o), 32'd1);
        chk("post_valid", 32'(valid_o), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        rst        = 1'b1;
        valid_i    = 1'b0;
        operator_i = 2'b00;
        op_a_i     = '0;
        op_b_i     = '0;
        kill_i     = 1'b0;
        ready_i    = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        run_op(2'b01, 32'd100, 32'd7, 5, 32'd14, 32, 1'b1);
        run_op(2'b11, 32'd100, 32'd7, 0, 32'd2, 32, 1'b1);
        run_op(2'b00, -32'sd7, 32'd2, 0, 32'hFFFF_FFFD, 33, 1'b1);
        run_op(2'b10, -32'sd7, 32'd2, 1, 32'hFFFF_FFFF, 33, 1'b1);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 34, 1'b1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 34, 1'b1);
        run_op(2'b01, 32'd5, 32'd0, 0, 32'hFFFF_FFFF, 2, 1'b1);
        run_op(2'b11, 32'd5, 32'd0, 0, 32'd5, 2, 1'b1);
        run_op(2'b00, -32'sd5, 32'd0, 0, 32'hFFFF_FFFF, 2, 1'b1);
        run_op(2'b10, -32'sd5, 32'd0, 2, 32'hFFFF_FFFB, 2, 1'b1);
        run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 0, 32'd1, 3, 1'b1);
        run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 0, 32'h7FFF_FFFF, 3, 1'b1);

        // kill together with valid in IDLE must not start anything
        valid_i    = 1'b1;
        kill_i     = 1'b1;
        operator_i = 2'b01;
        op_a_i     = 32'd50;
        op_b_i     = 32'd5;
        @(negedge clk);
        valid_i = 1'b0;
        kill_i  = 1'b0;
        chk("kill_accept_ready", 32'(ready_o), 32'd1);
        @(negedge clk);
        chk("kill_accept_clz_en", 32'(div_clz_en_o), 32'd0);

        // kill in the 4th DIVIDE cycle
        valid_i    = 1'b1;
        operator_i = 2'b01;
        op_a_i     = 32'd1000;
        op_b_i     = 32'd3;
        @(negedge clk);
        valid_i = 1'b0;
        chk("init_clz_en", 32'(div_clz_en_o), 32'd1);
        chk("init_shift_en", 32'(div_shift_en_o), 32'd1);
        chk("init_clz_data", div_clz_data_o, 32'd3);
        chk("init_shift_amt", 32'(div_shift_amt_o), 32'd30);
        repeat (4) @(negedge clk);
        chk("divide_clz_en", 32'(div_clz_en_o), 32'd0);
        chk("divide_ready", 32'(ready_o), 32'd0);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        chk("kill_ready", 32'(ready_o), 32'd1);
        chk("kill_valid", 32'(valid_o), 32'd0);
        repeat (40) @(negedge clk);
        chk("kill_quiet", 32'(valid_o), 32'd0);

        // asynchronous reset mid-DIVIDE
        valid_i    = 1'b1;
        operator_i = 2'b00;
        op_a_i     = 32'd77777;
        op_b_i     = -32'sd3;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(2'b01, 32'd9, 32'd3, 0, 32'd3, 33, 1'b1);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                3: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op(op, a, b, $urandom_range(0, 2), 32'd0, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
